// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB writeback arbiter.
//   CDB_XLEN        : datapath width
//   ROB_SIZE_WIDTH  : ROB id width
//   CDB_FIFO_DEPTH  : default skid FIFO depth per source
//   CDB_SRC_ALU/MEM : encoding of the cdb_src field
package cdb_arbiter_pkg;

    localparam int unsigned CDB_XLEN       = 32;
    localparam int unsigned ROB_SIZE_WIDTH = 5;
    localparam int unsigned CDB_FIFO_DEPTH = 2;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_MEM = 1'b1;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source skid FIFO holding results that could not be broadcast yet.
//   clk, rst_n   : clock, async active-low reset
//   en           : global enable; low freezes all state
//   clr          : synchronous clear (flush), wins over push/pop
//   push, push_* : enqueue one result (dropped when full)
//   pop          : dequeue the head entry
//   head_*_c     : head entry, combinational from state
//   count        : number of stored entries, 0..DEPTH
//   full_c       : count == DEPTH
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = CDB_FIFO_DEPTH,
    parameter int unsigned XLEN  = CDB_XLEN,
    parameter int unsigned ID_W  = ROB_SIZE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       push,
    input  logic [ID_W-1:0]            push_id,
    input  logic [XLEN-1:0]            push_val,
    input  logic                       pop,
    output logic [ID_W-1:0]            head_id_c,
    output logic [XLEN-1:0]            head_val_c,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  id_mem  [DEPTH];
    logic [XLEN-1:0]  val_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full_c     = (count == CNT_W'(DEPTH));
    assign do_push    = en && !clr && push && !full_c;
    assign do_pop     = en && !clr && pop && (count != '0);
    assign head_id_c  = id_mem[head];
    assign head_val_c = val_mem[head];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (clr) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + PTR_W'(1);
                if (do_pop)  head <= head + PTR_W'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Payload storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[tail]  <= push_id;
            val_mem[tail] <= push_val;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU and memory results onto one registered CDB.
//   clk, rst_n              : clock, async active-low reset
//   rdy                     : global enable; low freezes all state
//   flush                   : discard all pending results
//   alu_ready/alu_res/alu_id: ALU result input
//   mem_data_ready/mem_data/mem_id : load result input
//   alu_full, mem_full      : source FIFO full (combinational from state)
//   cdb_valid/id/val/src    : registered broadcast, src 0 = ALU, 1 = memory
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN  = CDB_XLEN,
    parameter int unsigned ID_W  = ROB_SIZE_WIDTH,
    parameter int unsigned DEPTH = CDB_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            flush,
    input  logic            alu_ready,
    input  logic [XLEN-1:0] alu_res,
    input  logic [ID_W-1:0] alu_id,
    input  logic            mem_data_ready,
    input  logic [XLEN-1:0] mem_data,
    input  logic [ID_W-1:0] mem_id,
    output logic            alu_full,
    output logic            mem_full,
    output logic            cdb_valid,
    output logic [ID_W-1:0] cdb_id,
    output logic [XLEN-1:0] cdb_val,
    output logic            cdb_src
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] alu_count;
    logic [CNT_W-1:0] mem_count;
    logic [ID_W-1:0]  alu_head_id;
    logic [ID_W-1:0]  mem_head_id;
    logic [XLEN-1:0]  alu_head_val;
    logic [XLEN-1:0]  mem_head_val;
    logic             alu_full_c;
    logic             mem_full_c;

    logic             alu_queued;
    logic             mem_queued;
    logic             alu_cand;
    logic             mem_cand;
    logic [ID_W-1:0]  alu_cand_id;
    logic [ID_W-1:0]  mem_cand_id;
    logic [XLEN-1:0]  alu_cand_val;
    logic [XLEN-1:0]  mem_cand_val;
    logic             grant_alu;
    logic             grant_mem;
    logic             alu_pop;
    logic             mem_pop;
    logic             alu_push;
    logic             mem_push;
    logic             last_grant;

    assign alu_full = alu_full_c;
    assign mem_full = mem_full_c;

    // Candidate selection and round-robin grant; a queued head always beats the live input.
    always_comb begin
        alu_queued   = (alu_count != '0);
        mem_queued   = (mem_count != '0);
        alu_cand     = alu_queued || alu_ready;
        mem_cand     = mem_queued || mem_data_ready;
        alu_cand_id  = alu_queued ? alu_head_id  : alu_id;
        alu_cand_val = alu_queued ? alu_head_val : alu_res;
        mem_cand_id  = mem_queued ? mem_head_id  : mem_id;
        mem_cand_val = mem_queued ? mem_head_val : mem_data;
        grant_alu    = alu_cand && (!mem_cand || (last_grant == CDB_SRC_MEM));
        grant_mem    = mem_cand && !grant_alu;
        alu_pop      = grant_alu && alu_queued;
        mem_pop      = grant_mem && mem_queued;
        // Live input is stored unless it went straight onto the bus this cycle.
        alu_push     = alu_ready && (alu_queued || !grant_alu);
        mem_push     = mem_data_ready && (mem_queued || !grant_mem);
    end

    cdb_src_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ID_W  (ID_W)
    ) u_alu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (rdy),
        .clr        (flush),
        .push       (alu_push),
        .push_id    (alu_id),
        .push_val   (alu_res),
        .pop        (alu_pop),
        .head_id_c  (alu_head_id),
        .head_val_c (alu_head_val),
        .count      (alu_count),
        .full_c     (alu_full_c)
    );

    cdb_src_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ID_W  (ID_W)
    ) u_mem_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (rdy),
        .clr        (flush),
        .push       (mem_push),
        .push_id    (mem_id),
        .push_val   (mem_data),
        .pop        (mem_pop),
        .head_id_c  (mem_head_id),
        .head_val_c (mem_head_val),
        .count      (mem_count),
        .full_c     (mem_full_c)
    );

    // Broadcast register and round-robin pointer; flush kills the next broadcast only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid  <= 1'b0;
            cdb_id     <= '0;
            cdb_val    <= '0;
            cdb_src    <= CDB_SRC_ALU;
            last_grant <= CDB_SRC_MEM;
        end else if (rdy) begin
            if (flush) begin
                cdb_valid <= 1'b0;
            end else if (grant_alu) begin
                cdb_valid  <= 1'b1;
                cdb_id     <= alu_cand_id;
                cdb_val    <= alu_cand_val;
                cdb_src    <= CDB_SRC_ALU;
                last_grant <= CDB_SRC_ALU;
            end else if (grant_mem) begin
                cdb_valid  <= 1'b1;
                cdb_id     <= mem_cand_id;
                cdb_val    <= mem_cand_val;
                cdb_src    <= CDB_SRC_MEM;
                last_grant <= CDB_SRC_MEM;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

    // Producers must hold off while their FIFO is full.
    always @(posedge clk) begin
        if (rst_n && rdy) begin
            assert (!(alu_ready && alu_full_c));
            assert (!(mem_data_ready && mem_full_c));
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ID_W  = 5;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] val;
    } ent_t;

    typedef struct {
        logic            v;
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] val;
        logic            src;
    } cdb_t;

    logic            clk;
    logic            rst_n;
    logic            rdy;
    logic            flush;
    logic            alu_ready;
    logic [XLEN-1:0] alu_res;
    logic [ID_W-1:0] alu_id;
    logic            mem_data_ready;
    logic [XLEN-1:0] mem_data;
    logic [ID_W-1:0] mem_id;
    logic            alu_full;
    logic            mem_full;
    logic            cdb_valid;
    logic [ID_W-1:0] cdb_id;
    logic [XLEN-1:0] cdb_val;
    logic            cdb_src;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pending entries per source, round-robin pointer, expected bus.
    ent_t qa[$];
    ent_t qm[$];
    cdb_t sb[$];
    logic            m_last_mem;
    logic            e_v;
    logic [ID_W-1:0] e_id;
    logic [XLEN-1:0] e_val;
    logic            e_src;

    cdb_arbiter #(
        .XLEN  (XLEN),
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .flush          (flush),
        .alu_ready      (alu_ready),
        .alu_res        (alu_res),
        .alu_id         (alu_id),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .mem_id         (mem_id),
        .alu_full       (alu_full),
        .mem_full       (mem_full),
        .cdb_valid      (cdb_valid),
        .cdb_id         (cdb_id),
        .cdb_val        (cdb_val),
        .cdb_src        (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qm.delete();
        m_last_mem = 1'b1;
        e_v   = 1'b0;
        e_id  = '0;
        e_val = '0;
        e_src = 1'b0;
    endtask

    // One clock: drive inputs, predict, advance, compare bus and occupancy.
    task automatic step(input logic av, input logic [ID_W-1:0] aid, input logic [XLEN-1:0] aval,
                        input logic mv, input logic [ID_W-1:0] mid, input logic [XLEN-1:0] mval,
                        input logic fl, input logic r);
        cdb_t got_e;
        ent_t e;
        logic a_c;
        logic m_c;
        av = av && (qa.size() < DEPTH);
        mv = mv && (qm.size() < DEPTH);
        alu_ready      = av;
        alu_id         = aid;
        alu_res        = aval;
        mem_data_ready = mv;
        mem_id         = mid;
        mem_data       = mval;
        flush          = fl;
        rdy            = r;
        #1;
        check("alu_full", alu_full, qa.size() == DEPTH);
        check("mem_full", mem_full, qm.size() == DEPTH);
        if (r) begin
            if (fl) begin
                qa.delete();
                qm.delete();
                e_v = 1'b0;
            end else begin
                if (av) qa.push_back({aid, aval});
                if (mv) qm.push_back({mid, mval});
                a_c = (qa.size() > 0);
                m_c = (qm.size() > 0);
                if (a_c && (!m_c || m_last_mem)) begin
                    e = qa.pop_front();
                    e_v = 1'b1; e_id = e.id; e_val = e.val; e_src = 1'b0;
                    m_last_mem = 1'b0;
                end else if (m_c) begin
                    e = qm.pop_front();
                    e_v = 1'b1; e_id = e.id; e_val = e.val; e_src = 1'b1;
                    m_last_mem = 1'b1;
                end else begin
                    e_v = 1'b0;
                end
            end
        end
        sb.push_back('{e_v, e_id, e_val, e_src});
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        check("cdb_valid", cdb_valid, got_e.v);
        check("cdb_id", cdb_id, got_e.id);
        check("cdb_val", cdb_val, got_e.val);
        check("cdb_src", cdb_src, got_e.src);
        check("alu_count", dut.u_alu_fifo.count, qa.size());
        check("mem_count", dut.u_mem_fifo.count, qm.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            if (qa.size() == 0 && qm.size() == 0) break;
            idle(1);
        end
        idle(1);
    endtask

    task automatic dual(input int n, input logic [ID_W-1:0] abase, input logic [ID_W-1:0] mbase);
        for (int i = 0; i < n; i++)
            step(1, abase + ID_W'(i), XLEN'(32'h100 + i), 1, mbase + ID_W'(i), XLEN'(32'h200 + i), 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        alu_ready = 1'b0;
        alu_res = '0;
        alu_id = '0;
        mem_data_ready = 1'b0;
        mem_data = '0;
        mem_id = '0;
        model_reset();
        #1;
        check("rst_valid", cdb_valid, 0);
        check("rst_id", cdb_id, 0);
        check("rst_val", cdb_val, 0);
        check("rst_src", cdb_src, 0);
        check("rst_alu_full", alu_full, 0);
        check("rst_mem_full", mem_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie right after reset: ALU first, then memory.
        step(1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0, 1);
        check("tie1_id", cdb_id, 1);
        check("tie1_src", cdb_src, 0);
        idle(1);
        check("tie1b_id", cdb_id, 2);
        check("tie1b_src", cdb_src, 1);
        idle(2);
        step(1, 5'd4, 32'hC, 1, 5'd5, 32'hD, 0, 1);
        check("tie2_src", cdb_src, 0);
        check("tie2_id", cdb_id, 4);
        idle(2);

        // Single ALU result: one-cycle latency, then bus goes idle.
        step(1, 5'd3, 32'h11, 0, '0, '0, 0, 1);
        check("single_valid", cdb_valid, 1);
        check("single_id", cdb_id, 3);
        check("single_val", cdb_val, 32'h11);
        check("single_src", cdb_src, 0);
        idle(1);
        check("single_gone", cdb_valid, 0);

        // Sustained dual traffic.
        dual(6, 5'd8, 5'd16);
        drain();

        // Fill: continuous dual traffic fills the losing source after three cycles.
        dual(3, 5'd0, 5'd10);
        check("fill_full", alu_full || mem_full, 1);
        dual(2, 5'd3, 5'd13);
        drain();

        // Flush with queued entries and live inputs in the flush cycle.
        dual(3, 5'd20, 5'd24);
        step(1, 5'd30, 32'hDEAD, 1, 5'd31, 32'hBEEF, 1, 1);
        check("flush_valid", cdb_valid, 0);
        check("flush_alu_full", alu_full, 0);
        check("flush_mem_full", mem_full, 0);
        idle(3);

        // rdy low freezes everything, then resumes in order.
        dual(2, 5'd6, 5'd12);
        for (int i = 0; i < 3; i++) step(1, 5'd29, 32'h5A5A, 1, 5'd28, 32'hA5A5, 0, 0);
        drain();

        // Asynchronous reset mid-queue.
        dual(3, 5'd1, 5'd9);
        rst_n = 1'b0;
        #1;
        check("arst_valid", cdb_valid, 0);
        check("arst_id", cdb_id, 0);
        check("arst_val", cdb_val, 0);
        check("arst_src", cdb_src, 0);
        check("arst_alu_cnt", dut.u_alu_fifo.count, 0);
        check("arst_mem_cnt", dut.u_mem_fifo.count, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        idle(2);
        step(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, 1);
        check("arst_tie_src", cdb_src, 0);
        drain();

        // Random traffic with occasional flush and stall.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ID_W'($urandom), XLEN'($urandom),
                 1'($urandom_range(0, 1)), ID_W'($urandom), XLEN'($urandom),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) != 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
